bf_prog_loader: RTL

BF_PROG_LOADER -- requirements
Module: bf_prog_loader

---
 rtl/bf_pkg.sv | 22 ++
 rtl/bf_prog_mem.sv | 34 +++
 rtl/bf_prog_loader.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/bf_pkg.sv
// ---------------------------------------------------------------------------
// bf_pkg
// Shared definitions for the program loader: the 3-bit opcode map of the
// instruction set and the loader state encoding.
// ---------------------------------------------------------------------------
package bf_pkg;

    localparam logic [2:0] OP_RIGHT = 3'd0;  // '>'
    localparam logic [2:0] OP_LEFT  = 3'd1;  // '<'
    localparam logic [2:0] OP_INC   = 3'd2;  // '+'
    localparam logic [2:0] OP_DEC   = 3'd3;  // '-'
    localparam logic [2:0] OP_OUT   = 3'd4;  // '.'
    localparam logic [2:0] OP_IN    = 3'd5;  // ','
    localparam logic [2:0] OP_LOOP  = 3'd6;  // '['
    localparam logic [2:0] OP_END   = 3'd7;  // ']'

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } bf_state_t;

endpackage

// File: rtl/bf_prog_mem.sv
// ---------------------------------------------------------------------------
// bf_prog_mem
// DEPTH x 3-bit program RAM. Synchronous write, asynchronous read.
// Ports:
//   clk    - clock, write on rising edge
//   we     - write enable
//   waddr  - write address
//   wdata  - opcode to store
//   raddr  - read address
//   rdata  - opcode at raddr (combinational)
// ---------------------------------------------------------------------------
module bf_prog_mem #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [2:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [2:0]    rdata
);

    logic [2:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bf_prog_loader.sv
// ---------------------------------------------------------------------------
// bf_prog_loader
// Switch-driven program entry for a small 8-opcode core. Each rising edge of
// push appends sw[2:0] to program memory; sw[6] clears the program, a rising
// sw[7] requests RUN. Bracket nesting is tracked during entry and RUN is only
// granted for a non-empty, balanced, error-free program.
// Ports:
//   clk      - clock
//   rst      - synchronous active-high reset
//   push     - entry strobe (level, rising edge accepted)
//   sw       - [2:0] opcode, [6] clear request, [7] run request
//   rd_addr  - core fetch address
//   rd_data  - opcode at rd_addr (asynchronous read)
//   prog_len - number of stored instructions, 0..DEPTH
//   start    - one-cycle pulse on entering RUN
//   running  - high in RUN
//   full     - prog_len == DEPTH
//   error    - sticky bracket-nesting error
//   led      - {running, error, prog_len[5:0]}
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_LOAD | program entry; pushes append, clear and run requests honoured
// ST_RUN  | core executing; memory and prog_len frozen until sw[7] drops
// ---------------------------------------------------------------------------
module bf_prog_loader
    import bf_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    sw,
    input  logic [AW-1:0] rd_addr,
    output logic [2:0]    rd_data,
    output logic [AW:0]   prog_len,
    output logic          start,
    output logic          running,
    output logic          full,
    output logic          error,
    output logic [7:0]    led
);

    localparam logic [AW:0] FULL_LEN = (AW+1)'(DEPTH);

    bf_state_t   state, state_n;
    logic        push_d, sw7_d;
    logic        push_edge, run_edge;
    logic [AW:0] depth, depth_n;
    logic [AW:0] len_n;
    logic        err_n, start_n;
    logic        we;

    assign push_edge = push & ~push_d;
    assign run_edge  = sw[7] & ~sw7_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_LOAD;
            prog_len <= '0;
            depth    <= '0;
            error    <= 1'b0;
            start    <= 1'b0;
            push_d   <= 1'b0;
            sw7_d    <= 1'b0;
        end else begin
            state    <= state_n;
            prog_len <= len_n;
            depth    <= depth_n;
            error    <= err_n;
            start    <= start_n;
            push_d   <= push;
            sw7_d    <= sw[7];
        end
    end

    always_comb begin
        state_n = state;
        len_n   = prog_len;
        depth_n = depth;
        err_n   = error;
        start_n = 1'b0;
        we      = 1'b0;
        case (state)
            ST_LOAD: begin
                // A run request in the same cycle as a push wins; the push is lost.
                if (run_edge) begin
                    if (!error && depth == '0 && prog_len != '0) begin
                        state_n = ST_RUN;
                        start_n = 1'b1;
                    end else if (depth != '0) begin
                        err_n = 1'b1;
                    end
                end else if (push_edge) begin
                    if (sw[6]) begin
                        len_n   = '0;
                        depth_n = '0;
                        err_n   = 1'b0;
                    end else if (!sw[7] && !full) begin
                        we    = 1'b1;
                        len_n = prog_len + 1'b1;
                        if (sw[2:0] == OP_LOOP) begin
                            depth_n = depth + 1'b1;
                        end else if (sw[2:0] == OP_END) begin
                            // Unmatched ']' is still stored; depth holds at 0.
                            if (depth == '0) begin
                                err_n = 1'b1;
                            end else begin
                                depth_n = depth - 1'b1;
                            end
                        end
                    end
                end
            end
            ST_RUN: begin
                if (!sw[7]) begin
                    state_n = ST_LOAD;
                end
            end
            default: state_n = ST_LOAD;
        endcase
    end

    bf_prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (prog_len[AW-1:0]),
        .wdata (sw[2:0]),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign running = (state == ST_RUN);
    assign full    = (prog_len == FULL_LEN);
    assign led     = {running, error, prog_len[5:0]};

endmodule
